pmem_burst_adaptor: RTL and testbench

- Responder on the cache's physical-memory port: accepts whole-line read (fill) and write (writeback) requests and raises a one-cycle resp_o when each completes.
- Converts each line request into a 4-beat burst transaction on the burst memory interface.
- Sits between the cache controller/datapath and main memory.

---
 rtl/pmem_burst_adaptor_pkg.sv | 28 ++
 rtl/pmem_burst_adaptor_burst_line_buffer.sv | 51 +++++
 rtl/pmem_burst_adaptor.sv | 153 +++++++++++++++
 tb/tb_pmem_burst_adaptor.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/pmem_burst_adaptor_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pmem_burst_adaptor_pkg
// Description : Shared cache/memory constants. These are the line and beat
//               geometry and the adaptor state encoding. The cache datapath
//               and the burst adaptor both use them, so their widths match.
// Ports       : (package, none)
// Revision    : 1.0 - initial release
// ============================================================================
package pmem_burst_adaptor_pkg;

  localparam int PMEM_LINE_BITS  = 256;
  localparam int PMEM_BURST_BITS = 64;
  localparam int PMEM_ADDR_WIDTH = 32;
  localparam int PMEM_BEATS      = PMEM_LINE_BITS / PMEM_BURST_BITS;
  localparam int PMEM_OFFSET     = $clog2(PMEM_LINE_BITS / 8);
  localparam int PMEM_BEAT_IDX_W = (PMEM_BEATS > 1) ? $clog2(PMEM_BEATS) : 1;

  // Adaptor state encoding
  typedef logic [1:0] adaptor_state_t;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

endpackage : pmem_burst_adaptor_pkg
`default_nettype wire

// File: rtl/pmem_burst_adaptor_burst_line_buffer.sv
`default_nettype none
// ============================================================================
// Module      : burst_line_buffer
// Description : Line-wide storage register. It loads a whole line, or writes a
//               single beat selected by an index. The selected beat is read
//               out through a mux.
// Ports       : clk, rst      - clock, synchronous active-high reset
//               load_i/line_i - whole-line load (takes priority)
//               beat_we_i     - write beat_i into slot beat_idx_i
//               beat_idx_i    - beat select for both write and read
//               beat_o        - beat currently selected by beat_idx_i
//               line_o        - full buffer contents
// Revision    : 1.0 - initial release
// ============================================================================
module burst_line_buffer
  import pmem_burst_adaptor_pkg::*;
#(
  parameter int LINE_BITS  = PMEM_LINE_BITS,
  parameter int BURST_BITS = PMEM_BURST_BITS,
  parameter int BEATS      = LINE_BITS / BURST_BITS,
  parameter int IDX_W      = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_i,
  input  logic [LINE_BITS-1:0]  line_i,
  input  logic                  beat_we_i,
  input  logic [IDX_W-1:0]      beat_idx_i,
  input  logic [BURST_BITS-1:0] beat_i,
  output logic [BURST_BITS-1:0] beat_o,
  output logic [LINE_BITS-1:0]  line_o
);

  // Beat 0 occupies the least-significant bits of the line.
  logic [BEATS-1:0][BURST_BITS-1:0] buf_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_q <= '0;
    end else if (load_i) begin
      buf_q <= line_i;
    end else if (beat_we_i) begin
      buf_q[beat_idx_i] <= beat_i;
    end
  end

  assign beat_o = buf_q[beat_idx_i];
  assign line_o = buf_q;

endmodule : burst_line_buffer
`default_nettype wire

// File: rtl/pmem_burst_adaptor.sv
`default_nettype none
// ============================================================================
// Module      : pmem_burst_adaptor
// Description : Responder on the cache physical-memory port. Each whole-line
//               fill or writeback becomes a BEATS-long burst on the memory
//               interface. A one-cycle resp_o pulse marks completion.
// Ports       : clk, rst               - clock, synchronous active-high reset
//               read_i, write_i        - line fill / writeback request (held)
//               address_i, line_i      - request address and writeback line
//               line_o, resp_o         - filled line, completion pulse
//               burst_i, burst_o       - memory read beat / write beat
//               address_o              - line-aligned burst address
//               read_o, write_o        - burst read / write request
//               resp_i                 - memory beat accepted / delivered
// Revision    : 1.0 - initial release
// ============================================================================
module pmem_burst_adaptor
  import pmem_burst_adaptor_pkg::*;
#(
  parameter int LINE_BITS  = PMEM_LINE_BITS,
  parameter int BURST_BITS = PMEM_BURST_BITS,
  parameter int ADDR_WIDTH = PMEM_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  read_i,
  input  logic                  write_i,
  input  logic [ADDR_WIDTH-1:0] address_i,
  input  logic [LINE_BITS-1:0]  line_i,
  output logic [LINE_BITS-1:0]  line_o,
  output logic                  resp_o,
  input  logic [BURST_BITS-1:0] burst_i,
  output logic [BURST_BITS-1:0] burst_o,
  output logic [ADDR_WIDTH-1:0] address_o,
  output logic                  read_o,
  output logic                  write_o,
  input  logic                  resp_i
);

  localparam int BEATS  = LINE_BITS / BURST_BITS;
  localparam int OFFSET = $clog2(LINE_BITS / 8);
  localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  adaptor_state_t          state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    w_load;
  logic                    w_beat_we;
  logic [BURST_BITS-1:0]   w_beat_rd;
  logic [ADDR_WIDTH-1:0]   w_addr_aligned;

  // The byte-offset bits are dropped on purpose. The burst always starts at
  // the line base.
  logic w_unused_addr_lsbs;
  assign w_unused_addr_lsbs = ^address_i[OFFSET-1:0];
  assign w_addr_aligned     = {address_i[ADDR_WIDTH-1:OFFSET], {OFFSET{1'b0}}};

  burst_line_buffer #(
    .LINE_BITS  (LINE_BITS),
    .BURST_BITS (BURST_BITS),
    .BEATS      (BEATS),
    .IDX_W      (CNT_W)
  ) u_line_buffer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (w_load),
    .line_i     (line_i),
    .beat_we_i  (w_beat_we),
    .beat_idx_i (cnt_q),
    .beat_i     (burst_i),
    .beat_o     (w_beat_rd),
    .line_o     (line_o)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    w_load    = 1'b0;
    w_beat_we = 1'b0;
    read_o    = 1'b0;
    write_o   = 1'b0;
    resp_o    = 1'b0;
    burst_o   = '0;
    address_o = '0;

    case (state_q)
      ST_IDLE: begin
        // A writeback wins over a fill when both are requested together.
        if (write_i) begin
          w_load  = 1'b1;
          addr_d  = w_addr_aligned;
          state_d = ST_WRITE;
        end else if (read_i) begin
          addr_d  = w_addr_aligned;
          state_d = ST_READ;
        end
      end

      ST_READ: begin
        read_o    = 1'b1;
        address_o = addr_q;
        if (resp_i) begin
          w_beat_we = 1'b1;
          if (cnt_q == LAST_BEAT) begin
            cnt_d   = '0;
            state_d = ST_DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      ST_WRITE: begin
        write_o   = 1'b1;
        address_o = addr_q;
        burst_o   = w_beat_rd;
        if (resp_i) begin
          if (cnt_q == LAST_BEAT) begin
            cnt_d   = '0;
            state_d = ST_DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      ST_DONE: begin
        resp_o  = 1'b1;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
    end
  end

endmodule : pmem_burst_adaptor
`default_nettype wire

// File: tb/tb_pmem_burst_adaptor.sv
`default_nettype none
// ============================================================================
// Module      : tb_pmem_burst_adaptor
// Description : Self-checking bench for pmem_burst_adaptor. Expected lines are
//               queued when a request is issued and compared on resp_o.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pmem_burst_adaptor;

  localparam int LB = 256;
  localparam int BB = 64;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          read_i, write_i, resp_i;
  logic [AW-1:0] address_i;
  logic [LB-1:0] line_i;
  logic [BB-1:0] burst_i;
  logic [LB-1:0] line_o;
  logic          resp_o, read_o, write_o;
  logic [BB-1:0] burst_o;
  logic [AW-1:0] address_o;

  int total = 0;
  int bad   = 0;
  logic [LB-1:0] exp_q[$];

  always #5 clk = ~clk;

  pmem_burst_adaptor dut (
    .clk       (clk),
    .rst       (rst),
    .read_i    (read_i),
    .write_i   (write_i),
    .address_i (address_i),
    .line_i    (line_i),
    .line_o    (line_o),
    .resp_o    (resp_o),
    .burst_i   (burst_i),
    .burst_o   (burst_o),
    .address_o (address_o),
    .read_o    (read_o),
    .write_o   (write_o),
    .resp_i    (resp_i)
  );

  task automatic check_value(input string tag, input logic [LB-1:0] act,
                             input logic [LB-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Scoreboard: every resp_o must match the oldest outstanding request.
  always @(negedge clk) begin
    if (read_o || write_o)
      check_value("rw_exclusive", LB'(read_o & write_o), '0);
    if (resp_o) begin
      if (exp_q.size() == 0)
        check_value("unexpected_resp", LB'(1), '0);
      else
        check_value("line_o", line_o, exp_q.pop_front());
    end
  end

  task automatic do_read(input logic [AW-1:0] addr, input logic [LB-1:0] line,
                         input int gap);
    read_i    = 1'b1;
    address_i = addr;
    exp_q.push_back(line);
    tick();
    address_i = ~addr;
    check_value("rd_read_o", LB'(read_o), LB'(1));
    check_value("rd_addr", LB'(address_o), LB'(addr & 32'hFFFF_FFE0));
    for (int b = 0; b < 4; b++) begin
      for (int g = 0; g < gap; g++) begin
        resp_i  = 1'b0;
        burst_i = {$urandom, $urandom};
        tick();
        check_value("rd_gap_read_o", LB'(read_o), LB'(1));
      end
      resp_i  = 1'b1;
      burst_i = line[b*BB +: BB];
      tick();
      if (b < 3) check_value("rd_early_resp", LB'(resp_o), '0);
    end
    resp_i = 1'b0;
    read_i = 1'b0;
    check_value("rd_resp", LB'(resp_o), LB'(1));
    tick();
    check_value("rd_resp_pulse", LB'(resp_o), '0);
    check_value("rd_read_o_off", LB'(read_o), '0);
  endtask

  task automatic do_write(input logic [AW-1:0] addr, input logic [LB-1:0] line,
                          input int gap, input logic also_read);
    write_i   = 1'b1;
    read_i    = also_read;
    address_i = addr;
    line_i    = line;
    exp_q.push_back(line);
    tick();
    line_i    = ~line;
    address_i = ~addr;
    check_value("wr_read_o", LB'(read_o), '0);
    check_value("wr_addr", LB'(address_o), LB'(addr & 32'hFFFF_FFE0));
    for (int b = 0; b < 4; b++) begin
      for (int g = 0; g < gap; g++) begin
        check_value("wr_gap_burst", LB'(burst_o), LB'(line[b*BB +: BB]));
        resp_i = 1'b0;
        tick();
      end
      check_value("wr_burst", LB'(burst_o), LB'(line[b*BB +: BB]));
      check_value("wr_write_o", LB'(write_o), LB'(1));
      resp_i = 1'b1;
      tick();
    end
    resp_i  = 1'b0;
    write_i = 1'b0;
    read_i  = 1'b0;
    check_value("wr_resp", LB'(resp_o), LB'(1));
    tick();
    check_value("wr_resp_pulse", LB'(resp_o), '0);
    check_value("wr_write_o_off", LB'(write_o), '0);
  endtask

  logic [LB-1:0] rd_line, wr_line;

  initial begin
    rst = 1'b1; read_i = 1'b0; write_i = 1'b0; resp_i = 1'b0;
    address_i = '0; line_i = '0; burst_i = '0;
    repeat (3) tick();
    rst = 1'b0;

    // Idle, with stray resp_i that must be ignored.
    for (int i = 0; i < 3; i++) begin
      resp_i = (i == 1);
      tick();
      check_value("idle_read_o", LB'(read_o), '0);
      check_value("idle_write_o", LB'(write_o), '0);
      check_value("idle_resp_o", LB'(resp_o), '0);
      check_value("idle_addr", LB'(address_o), '0);
      check_value("idle_burst", LB'(burst_o), '0);
      check_value("idle_line", line_o, '0);
    end
    resp_i = 1'b0;

    rd_line = {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}};
    do_read(32'h0000_1234, rd_line, 0);

    wr_line = {{$urandom, $urandom}, {$urandom, $urandom},
               {$urandom, $urandom}, {$urandom, $urandom}};
    do_write(32'h8000_00FF, wr_line, 2, 1'b0);

    // Both requests together: the writeback goes first with no read_o.
    wr_line = {8{$urandom}};
    do_write(32'h1000_0047, wr_line, 1, 1'b1);

    // A fill raised in the IDLE cycle right after the writeback response.
    rd_line = {8{$urandom}};
    do_read(32'h2222_3339, rd_line, 0);

    // Abort after two read beats.
    read_i    = 1'b1;
    address_i = 32'h0000_4444;
    tick();
    for (int b = 0; b < 2; b++) begin
      resp_i  = 1'b1;
      burst_i = {2{$urandom}};
      tick();
    end
    resp_i = 1'b0;
    read_i = 1'b0;
    rst    = 1'b1;
    tick();
    check_value("abort_read_o", LB'(read_o), '0);
    check_value("abort_resp_o", LB'(resp_o), '0);
    check_value("abort_addr", LB'(address_o), '0);
    check_value("abort_line", line_o, '0);
    rst = 1'b0;
    tick();

    rd_line = {8{$urandom}};
    do_read(32'h0000_4444, rd_line, 1);

    repeat (3) tick();
    check_value("sb_empty", LB'(exp_q.size()), '0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_pmem_burst_adaptor
`default_nettype wire
